branch_unit: RTL and testbench
==============================

BRANCH_UNIT -- requirements
Module: branch_unit

Interface
REQ-001 Parameter COUNT_WIDTH, default 32, width of statistics counters.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 in_valid  input  1  issue request.
REQ-005 in_ready  output  1  unit can accept the request this cycle.
REQ-006 in_pc, in_imm, in_rs1, in_rs2  input  32 each  instruction PC, sign-extended immediate, operand values.
REQ-007 in_kind  input  2  operation: 00 none, 01 conditional branch, 10 jal, 11 jalr.
REQ-008 in_funct3  input  3  branch condition code.
REQ-009 cmp_input_a, cmp_input_b  output  32 each  operands to comparator.
REQ-010 cmp_function_select  output  3  comparator function code.
REQ-011 cmp_result  input  1  comparator result, registered with 1-cycle latency.
REQ-012 stall  input  1  downstream hold.
REQ-013 flush  input  1  kill all in-flight work.
REQ-014 out_valid  output  1  instruction resolved this cycle.
REQ-015 out_link  output  32  pc+4 of the resolving instruction.
REQ-016 redirect_valid, redirect_pc  output  1, 32  fetch redirect.
REQ-017 trap_valid, trap_value  output  1, 32  misaligned-target trap and faulting target.
REQ-018 count_resolved, count_taken  output  COUNT_WIDTH each  conditional-branch statistics.

Function
REQ-019 Comparator drive SHALL be combinational pass-through: cmp_input_a=in_rs1, cmp_input_b=in_rs2, cmp_function_select=in_funct3, every cycle.
REQ-020 Accept SHALL occur on in_valid && in_ready && !flush; accepted fields load the resolve stage (RS) at that edge.
REQ-021 Target SHALL be computed at accept: kinds 01/10 -> in_pc+in_imm; kind 11 -> (in_rs1+in_imm) with bit 0 cleared; modulo 2^32; registered with pc+4.
REQ-022 in_ready SHALL equal !(rs_valid && stall).
REQ-023 RS states: EMPTY, FRESH (first cycle after load), HELD (stalled after FRESH); EMPTY->FRESH on accept; FRESH->HELD on stall; FRESH/HELD->EMPTY on resolve with no accept; resolve plus accept -> FRESH.
REQ-024 In FRESH, taken SHALL use cmp_result directly for kind 01; the value SHALL be captured into taken_q; HELD SHALL use taken_q, ignoring cmp_result.
REQ-025 Kinds 10/11 SHALL be taken; kind 00 SHALL be not-taken.
REQ-026 Resolve SHALL occur in a cycle with rs_valid && !stall && !flush; outputs are combinational from RS state, giving 1-cycle latency accept->resolve.
REQ-027 On resolve: out_valid=1, out_link=pc+4; if taken and target[1]==0 -> redirect_valid=1, redirect_pc=target; if taken and target[1]==1 -> trap_valid=1, trap_value=target, no redirect.
REQ-028 redirect_valid, trap_valid, out_valid SHALL be single-cycle pulses and 0 while stall=1.
REQ-029 Any request accepted in the same cycle as redirect_valid or trap_valid SHALL be discarded (wrong path); RS goes EMPTY.
REQ-030 flush SHALL dominate: RS -> EMPTY, no outputs asserted, no counter update, input not accepted that cycle.
REQ-031 count_resolved SHALL increment on each resolve of kind 01; count_taken additionally when taken, including trapped; both wrap modulo 2^COUNT_WIDTH.
REQ-032 Output data buses SHALL be 0 when their valid is 0.

Reset
REQ-033 reset SHALL asynchronously force RS EMPTY, taken_q=0, both counters=0; all valid outputs 0 and data outputs 0 while reset is held.
REQ-034 Reset asserted mid-stall SHALL discard the held instruction with no output pulse after release.
REQ-035 The first accept SHALL be possible on the first rising edge after reset deasserts.

Verification
REQ-036 beq, pc=0x100, imm=0x20, rs1=rs2=5, cmp_result=1 next cycle -> one cycle later redirect_pc=0x120, out_link=0x104, count_taken=1.
REQ-037 bne, pc=0x200, cmp_result=0 -> out_valid=1, redirect_valid=0, count_resolved=1, count_taken=0.
REQ-038 jalr, rs1=0x1003, imm=0 -> target 0x1002, trap_valid=1, trap_value=0x1002, no redirect.
REQ-039 Taken branch, stall=1 for 3 cycles, cmp_result toggled during stall -> single redirect after stall drops, using the FRESH-cycle value.
REQ-040 Taken redirect with a new accept the same cycle -> the new request is discarded, no out_valid next cycle; flush with rs_valid -> no pulses, counters unchanged.
REQ-041 COUNT_WIDTH=4, 16 resolved branches -> count_resolved wraps to 0.

Source files
------------

// File: rtl/branch_unit.sv
// Branch resolve stage: computes targets at issue, resolves one cycle later using
// the external comparator, and raises redirect/trap pulses plus branch statistics.
module branch_unit #(
    parameter int unsigned COUNT_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [31:0]            in_pc,
    input  logic [31:0]            in_imm,
    input  logic [31:0]            in_rs1,
    input  logic [31:0]            in_rs2,
    input  logic [1:0]             in_kind,
    input  logic [2:0]             in_funct3,
    output logic [31:0]            cmp_input_a,
    output logic [31:0]            cmp_input_b,
    output logic [2:0]             cmp_function_select,
    input  logic                   cmp_result,
    input  logic                   stall,
    input  logic                   flush,
    output logic                   out_valid,
    output logic [31:0]            out_link,
    output logic                   redirect_valid,
    output logic [31:0]            redirect_pc,
    output logic                   trap_valid,
    output logic [31:0]            trap_value,
    output logic [COUNT_WIDTH-1:0] count_resolved,
    output logic [COUNT_WIDTH-1:0] count_taken
);

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_FRESH = 2'd1;
    localparam logic [1:0] ST_HELD  = 2'd2;

    localparam logic [1:0] KIND_NONE = 2'b00;
    localparam logic [1:0] KIND_BR   = 2'b01;
    localparam logic [1:0] KIND_JAL  = 2'b10;
    localparam logic [1:0] KIND_JALR = 2'b11;

    logic [1:0]             state_q, state_d;
    logic [1:0]             kind_q, kind_d;
    logic [31:0]            target_q, target_d;
    logic [31:0]            link_q, link_d;
    logic                   taken_q, taken_d;
    logic [COUNT_WIDTH-1:0] cnt_res_q, cnt_res_d;
    logic [COUNT_WIDTH-1:0] cnt_tkn_q, cnt_tkn_d;

    logic        rs_valid;
    logic        accept;
    logic        resolve;
    logic        taken;
    logic        redirect_fire;
    logic        trap_fire;
    logic [31:0] jalr_sum;
    logic [31:0] accept_target;

    assign cmp_input_a         = in_rs1;
    assign cmp_input_b         = in_rs2;
    assign cmp_function_select = in_funct3;

    always_comb begin
        rs_valid = (state_q != ST_EMPTY);
        in_ready = !(rs_valid && stall);
        accept   = in_valid && in_ready && !flush;
        resolve  = rs_valid && !stall && !flush;

        // The comparator answer is only live in the first cycle after load.
        case (kind_q)
            KIND_BR:   taken = (state_q == ST_FRESH) ? cmp_result : taken_q;
            KIND_JAL,
            KIND_JALR: taken = 1'b1;
            default:   taken = 1'b0;
        endcase

        redirect_fire = resolve && taken && !target_q[1];
        trap_fire     = resolve && taken && target_q[1];

        jalr_sum      = in_rs1 + in_imm;
        accept_target = (in_kind == KIND_JALR) ? {jalr_sum[31:1], 1'b0} : (in_pc + in_imm);
    end

    always_comb begin
        state_d   = state_q;
        kind_d    = kind_q;
        target_d  = target_q;
        link_d    = link_q;
        taken_d   = (state_q == ST_FRESH) ? cmp_result : taken_q;
        cnt_res_d = cnt_res_q;
        cnt_tkn_d = cnt_tkn_q;

        if (resolve && (kind_q == KIND_BR)) begin
            cnt_res_d = cnt_res_q + COUNT_WIDTH'(1);
            if (taken) begin
                cnt_tkn_d = cnt_tkn_q + COUNT_WIDTH'(1);
            end
        end

        // A request arriving alongside a redirect/trap is on the wrong path and is dropped.
        if (flush) begin
            state_d = ST_EMPTY;
        end else if (accept && !(redirect_fire || trap_fire)) begin
            state_d  = ST_FRESH;
            kind_d   = in_kind;
            target_d = accept_target;
            link_d   = in_pc + 32'd4;
        end else if (accept || resolve) begin
            state_d = ST_EMPTY;
        end else if ((state_q == ST_FRESH) && stall) begin
            state_d = ST_HELD;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_EMPTY;
            kind_q    <= KIND_NONE;
            target_q  <= '0;
            link_q    <= '0;
            taken_q   <= 1'b0;
            cnt_res_q <= '0;
            cnt_tkn_q <= '0;
        end else begin
            state_q   <= state_d;
            kind_q    <= kind_d;
            target_q  <= target_d;
            link_q    <= link_d;
            taken_q   <= taken_d;
            cnt_res_q <= cnt_res_d;
            cnt_tkn_q <= cnt_tkn_d;
        end
    end

    assign out_valid      = resolve;
    assign out_link       = resolve ? link_q : '0;
    assign redirect_valid = redirect_fire;
    assign redirect_pc    = redirect_fire ? target_q : '0;
    assign trap_valid     = trap_fire;
    assign trap_value     = trap_fire ? target_q : '0;
    assign count_resolved = cnt_res_q;
    assign count_taken    = cnt_tkn_q;

endmodule

// File: tb/tb_branch_unit.sv
// Self-checking bench for branch_unit: transaction-level reference model with a
// per-cycle compare process, directed literal scenarios and a randomized phase.
module tb_branch_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_pc = '0, in_imm = '0, in_rs1 = '0, in_rs2 = '0;
    logic [1:0]  in_kind = '0;
    logic [2:0]  in_funct3 = '0;
    logic [31:0] cmp_input_a, cmp_input_b;
    logic [2:0]  cmp_function_select;
    logic        cmp_result = 1'b0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        out_valid, redirect_valid, trap_valid;
    logic [31:0] out_link, redirect_pc, trap_value;
    logic [31:0] count_resolved, count_taken;

    logic        in_ready4, out_valid4, redirect_valid4, trap_valid4;
    logic [31:0] cmp_a4, cmp_b4, out_link4, redirect_pc4, trap_value4;
    logic [2:0]  cmp_f4;
    logic [3:0]  count_resolved4, count_taken4;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    branch_unit dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_imm(in_imm), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_kind(in_kind), .in_funct3(in_funct3),
        .cmp_input_a(cmp_input_a), .cmp_input_b(cmp_input_b),
        .cmp_function_select(cmp_function_select), .cmp_result(cmp_result),
        .stall(stall), .flush(flush), .out_valid(out_valid), .out_link(out_link),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .trap_valid(trap_valid), .trap_value(trap_value),
        .count_resolved(count_resolved), .count_taken(count_taken)
    );

    branch_unit #(.COUNT_WIDTH(4)) dut4 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready4),
        .in_pc(in_pc), .in_imm(in_imm), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_kind(in_kind), .in_funct3(in_funct3),
        .cmp_input_a(cmp_a4), .cmp_input_b(cmp_b4),
        .cmp_function_select(cmp_f4), .cmp_result(cmp_result),
        .stall(stall), .flush(flush), .out_valid(out_valid4), .out_link(out_link4),
        .redirect_valid(redirect_valid4), .redirect_pc(redirect_pc4),
        .trap_valid(trap_valid4), .trap_value(trap_value4),
        .count_resolved(count_resolved4), .count_taken(count_taken4)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got=%h expected=%h", name, $time, got, exp);
        end
    endtask

    // Reference model: at most one pending instruction, tracked by its age in cycles.
    logic        m_valid;
    int          m_age;
    logic [1:0]  m_kind;
    logic [31:0] m_target, m_link;
    logic        m_first_cmp;
    logic [31:0] m_cres, m_ctkn;

    typedef struct packed {
        logic        ready;
        logic        resolve;
        logic        taken;
        logic        rv;
        logic        tv;
        logic [31:0] link;
        logic [31:0] rpc;
        logic [31:0] tval;
    } exp_t;

    function automatic exp_t calc();
        exp_t e;
        e.ready   = !(m_valid && stall);
        e.resolve = m_valid && !stall && !flush;
        if (m_kind == 2'b01)      e.taken = (m_age == 1) ? cmp_result : m_first_cmp;
        else if (m_kind == 2'b00) e.taken = 1'b0;
        else                      e.taken = 1'b1;
        e.rv   = e.resolve && e.taken && (m_target[1] == 1'b0);
        e.tv   = e.resolve && e.taken && (m_target[1] == 1'b1);
        e.link = e.resolve ? m_link : 32'd0;
        e.rpc  = e.rv ? m_target : 32'd0;
        e.tval = e.tv ? m_target : 32'd0;
        return e;
    endfunction

    exp_t e_now;
    always_comb e_now = calc();

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_valid <= 1'b0; m_age <= 0; m_kind <= 2'b00; m_target <= '0; m_link <= '0;
            m_first_cmp <= 1'b0; m_cres <= '0; m_ctkn <= '0;
        end else begin
            if (m_valid && m_age == 1) m_first_cmp <= cmp_result;
            if (e_now.resolve && m_kind == 2'b01) begin
                m_cres <= m_cres + 1;
                if (e_now.taken) m_ctkn <= m_ctkn + 1;
            end
            if (flush) begin
                m_valid <= 1'b0;
            end else if (in_valid && e_now.ready && !(e_now.rv || e_now.tv)) begin
                m_valid  <= 1'b1;
                m_age    <= 1;
                m_kind   <= in_kind;
                m_target <= (in_kind == 2'b11) ? ((in_rs1 + in_imm) & 32'hFFFF_FFFE) : (in_pc + in_imm);
                m_link   <= in_pc + 4;
            end else if ((in_valid && e_now.ready) || e_now.resolve) begin
                m_valid <= 1'b0;
            end else if (m_valid) begin
                m_age <= m_age + 1;
            end
        end
    end

    always @(negedge clk) begin
        chk("in_ready", {31'd0, in_ready}, {31'd0, e_now.ready});
        chk("out_valid", {31'd0, out_valid}, {31'd0, e_now.resolve});
        chk("out_link", out_link, e_now.link);
        chk("redirect_valid", {31'd0, redirect_valid}, {31'd0, e_now.rv});
        chk("redirect_pc", redirect_pc, e_now.rpc);
        chk("trap_valid", {31'd0, trap_valid}, {31'd0, e_now.tv});
        chk("trap_value", trap_value, e_now.tval);
        chk("count_resolved", count_resolved, m_cres);
        chk("count_taken", count_taken, m_ctkn);
        chk("count_resolved_w4", {28'd0, count_resolved4}, {28'd0, m_cres[3:0]});
        chk("count_taken_w4", {28'd0, count_taken4}, {28'd0, m_ctkn[3:0]});
        chk("pulses_w4", {29'd0, out_valid4, redirect_valid4, trap_valid4},
            {29'd0, e_now.resolve, e_now.rv, e_now.tv});
        chk("cmp_passthru", cmp_input_a ^ cmp_input_b ^ {29'd0, cmp_function_select},
            in_rs1 ^ in_rs2 ^ {29'd0, in_funct3});
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic [1:0] k, input logic [2:0] f3, input logic [31:0] pc,
                          input logic [31:0] imm, input logic [31:0] rs1, input logic [31:0] rs2);
        in_valid = 1'b1; in_kind = k; in_funct3 = f3;
        in_pc = pc; in_imm = imm; in_rs1 = rs1; in_rs2 = rs2;
    endtask

    initial begin
        repeat (2) step();
        reset = 1'b0;
        // beq taken: first accept right after reset release
        set_in(2'b01, 3'b000, 32'h100, 32'h20, 32'd5, 32'd5); step();
        in_valid = 1'b0; cmp_result = 1'b1;
        @(negedge clk);
        chk("lit_beq_redirect_valid", {31'd0, redirect_valid}, 32'd1);
        chk("lit_beq_redirect_pc", redirect_pc, 32'h120);
        chk("lit_beq_link", out_link, 32'h104);
        step(); cmp_result = 1'b0;
        @(negedge clk);
        chk("lit_beq_count_taken", count_taken, 32'd1);
        // bne not taken
        set_in(2'b01, 3'b001, 32'h200, 32'h8, 32'd5, 32'd6); step();
        in_valid = 1'b0; cmp_result = 1'b0;
        @(negedge clk);
        chk("lit_bne_out_valid", {31'd0, out_valid}, 32'd1);
        chk("lit_bne_redirect_valid", {31'd0, redirect_valid}, 32'd0);
        step();
        @(negedge clk);
        chk("lit_bne_count_resolved", count_resolved, 32'd2);
        chk("lit_bne_count_taken", count_taken, 32'd1);
        // jalr misaligned target
        set_in(2'b11, 3'b000, 32'h300, 32'h0, 32'h1003, 32'h0); step();
        in_valid = 1'b0;
        @(negedge clk);
        chk("lit_jalr_trap_valid", {31'd0, trap_valid}, 32'd1);
        chk("lit_jalr_trap_value", trap_value, 32'h1002);
        chk("lit_jalr_no_redirect", {31'd0, redirect_valid}, 32'd0);
        step();
        // stalled branch keeps the FRESH-cycle comparator answer
        set_in(2'b01, 3'b000, 32'h300, 32'h40, 32'd1, 32'd1); step();
        in_valid = 1'b0; stall = 1'b1; cmp_result = 1'b1;
        @(negedge clk);
        chk("lit_stall_out_valid", {31'd0, out_valid}, 32'd0);
        chk("lit_stall_in_ready", {31'd0, in_ready}, 32'd0);
        step(); cmp_result = 1'b0;
        step(); cmp_result = 1'b1;
        step(); stall = 1'b0; cmp_result = 1'b0;
        @(negedge clk);
        chk("lit_stall_redirect_valid", {31'd0, redirect_valid}, 32'd1);
        chk("lit_stall_redirect_pc", redirect_pc, 32'h340);
        step();
        @(negedge clk);
        chk("lit_stall_single_pulse", {31'd0, redirect_valid}, 32'd0);
        // wrong-path request discarded
        set_in(2'b10, 3'b000, 32'h400, 32'h10, 32'h0, 32'h0); step();
        set_in(2'b01, 3'b000, 32'h500, 32'h4, 32'h0, 32'h0); cmp_result = 1'b1;
        @(negedge clk);
        chk("lit_jal_redirect_pc", redirect_pc, 32'h410);
        step(); in_valid = 1'b0;
        @(negedge clk);
        chk("lit_wrongpath_no_out", {31'd0, out_valid}, 32'd0);
        step();
        // flush kills a pending branch
        set_in(2'b01, 3'b000, 32'h600, 32'h8, 32'h0, 32'h0); cmp_result = 1'b0; step();
        in_valid = 1'b0; flush = 1'b1; cmp_result = 1'b1;
        @(negedge clk);
        chk("lit_flush_no_out", {31'd0, out_valid | redirect_valid}, 32'd0);
        step(); flush = 1'b0;
        @(negedge clk);
        chk("lit_flush_after_out", {31'd0, out_valid}, 32'd0);
        chk("lit_flush_count_resolved", count_resolved, 32'd3);
        chk("lit_flush_count_taken", count_taken, 32'd2);
        step();
        // reset during stall drops the held branch
        set_in(2'b01, 3'b000, 32'h700, 32'h8, 32'h0, 32'h0); step();
        in_valid = 1'b0; stall = 1'b1; cmp_result = 1'b1; step();
        reset = 1'b1;
        @(negedge clk);
        chk("lit_reset_count", count_resolved, 32'd0);
        step(); reset = 1'b0; stall = 1'b0;
        @(negedge clk);
        chk("lit_reset_no_pulse", {31'd0, out_valid | redirect_valid}, 32'd0);
        step();
        // 16 back-to-back resolved branches wrap the 4-bit counter
        for (int i = 0; i < 16; i++) begin
            set_in(2'b01, 3'b000, 32'h800 + 32'(i * 16), 32'h40, 32'h0, 32'h0);
            cmp_result = 1'b0;
            step();
        end
        in_valid = 1'b0;
        step();
        @(negedge clk);
        chk("lit_wrap_w32", count_resolved, 32'd16);
        chk("lit_wrap_w4", {28'd0, count_resolved4}, 32'd0);
        step();
        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            reset      = ($urandom_range(0, 299) == 0);
            in_valid   = ($urandom_range(0, 3) != 0);
            in_kind    = 2'($urandom);
            in_funct3  = 3'($urandom);
            in_pc      = $urandom & 32'hFFFF_FFFC;
            in_imm     = ($urandom_range(0, 1) == 0) ? ($urandom & 32'h0000_0FFE) : $urandom;
            in_rs1     = $urandom;
            in_rs2     = $urandom;
            cmp_result = 1'($urandom);
            stall      = ($urandom_range(0, 4) == 0);
            flush      = ($urandom_range(0, 11) == 0);
            step();
        end
        reset = 1'b0; in_valid = 1'b0; stall = 1'b0; flush = 1'b0;
        repeat (3) step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
